// File: rtl/picorv_dma_pkg.sv
// Shared types and defaults for the PicoRV DMA bus slice: FSM state encoding,
// request record and default sizing constants.
package picorv_dma_pkg;

  localparam int DEF_TIMEOUT_CYCLES  = 256;
  localparam int DEF_MAX_OUTSTANDING = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    ABORT
  } wb_state_e;

  typedef struct packed {
    logic [31:2] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } wb_req_t;

endpackage

// File: rtl/picorv_wb_req_fifo.sv
// Two-entry request buffer between the PicoRV master port and the downstream bus.
// Flush takes priority over push and pop so an abort always leaves it empty.
module picorv_wb_req_fifo
  import picorv_dma_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  wb_req_t    push_data,
  output wb_req_t    head,
  output logic [1:0] count
);

  wb_req_t mem [2];
  logic    wr_ptr;
  logic    rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count alone
  // decide which entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/picorv_wb_slice.sv
// Pipelined Wishbone slice between the PicoRV burst master and the DMA interconnect,
// with bounded outstanding requests, response timeout and upstream-abort handling.
module picorv_wb_slice
  import picorv_dma_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_stall_o,
  output logic        wbs_err_o,
  output logic [31:2] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_stall_i,
  input  logic        wbm_err_i
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  wb_state_e     state;
  logic [2:0]    outstanding;
  logic [TW-1:0] tcnt;
  logic [1:0]    fifo_count;
  wb_req_t       push_data;
  wb_req_t       head;
  logic          push, pop, resp, busy, up_abort, timeout, abort;

  // Stall depends only on registered state, never on wbm_stall_i, and it also
  // blocks pushes while in ABORT.
  assign wbs_stall_o = (fifo_count == 2'd2) || (state == ABORT);
  assign push        = wbs_cyc_i && wbs_stb_i && !wbs_stall_o;
  assign wbm_stb_o   = (fifo_count != 2'd0) && (outstanding < 3'(MAX_OUTSTANDING))
                       && (state == ACTIVE);
  assign pop         = wbm_stb_o && !wbm_stall_i;
  assign resp        = (wbm_ack_i || wbm_err_i) && (outstanding != 3'd0);
  assign busy        = (fifo_count != 2'd0) || (outstanding != 3'd0);
  assign up_abort    = (state == ACTIVE) && !wbs_cyc_i && busy;
  assign timeout     = (state == ACTIVE) && (outstanding != 3'd0) && !resp
                       && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign abort       = up_abort || timeout;
  assign wbm_cyc_o   = (state == ACTIVE) && (wbs_cyc_i || busy);

  assign push_data = '{adr: wbs_adr_i, dat: wbs_dat_i, we: wbs_we_i, sel: wbs_sel_i};
  assign wbm_adr_o = head.adr;
  assign wbm_dat_o = head.dat;
  assign wbm_we_o  = head.we;
  assign wbm_sel_o = head.sel;

  picorv_wb_req_fifo u_req_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (abort),
    .push_data (push_data),
    .head      (head),
    .count     (fifo_count)
  );

  // NOTE: all state below updates with non-blocking assignments so every
  // right-hand side sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      outstanding <= 3'd0;
      tcnt        <= '0;
      wbs_ack_o   <= 1'b0;
      wbs_err_o   <= 1'b0;
      wbs_dat_o   <= 32'd0;
    end else begin
      wbs_ack_o <= wbm_ack_i && (outstanding != 3'd0) && !up_abort;
      wbs_err_o <= (wbm_err_i && (outstanding != 3'd0) && !up_abort) || timeout;
      if (wbm_ack_i && (outstanding != 3'd0)) wbs_dat_o <= wbm_dat_i;

      if (abort) begin
        outstanding <= 3'd0;
        tcnt        <= '0;
      end else begin
        outstanding <= outstanding + 3'(pop) - 3'(resp);
        if (resp || pop || (outstanding == 3'd0)) tcnt <= '0;
        else                                      tcnt <= tcnt + TW'(1);
      end

      case (state)
        IDLE:    if (wbs_cyc_i) state <= ACTIVE;
        ACTIVE:  if (abort) state <= ABORT;
                 else if (!wbs_cyc_i && !busy) state <= IDLE;
        ABORT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picorv_wb_slice.sv
// Scoreboard bench for picorv_wb_slice: upstream requests are queued as expected
// downstream requests and upstream responses, then popped as the DUT produces them.
module tb_picorv_wb_slice;
  import picorv_dma_pkg::*;

  localparam int TO   = 16;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:2] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_stb_i, wbs_cyc_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o, wbs_stall_o, wbs_err_o;
  logic [31:2] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_stb_o, wbm_cyc_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i, wbm_stall_i, wbm_err_i;

  typedef struct { bit is_read; logic [31:0] data; } rsp_t;
  typedef struct { int due; logic [31:0] data; } pend_t;

  wb_req_t exp_req_q[$];
  rsp_t    rsp_q[$];
  pend_t   pend_q[$];

  int checks, failures;
  int cyc_n, occ, out_m, ack_count, err_count, sim_hits, last_pop, ack_delay;
  bit model_on, slave_on, saw_stall;

  picorv_wb_slice #(.TIMEOUT_CYCLES(TO), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_stall_o(wbs_stall_o),
    .wbs_err_o(wbs_err_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_stall_i(wbm_stall_i),
    .wbm_err_i(wbm_err_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:2] adr);
    if (adr == 30'h400) return 32'hDEAD_BEEF;
    return {adr, 2'b00} ^ 32'h5A5A_0000;
  endfunction

  // Downstream slave: acks each accepted request ack_delay cycles after acceptance.
  initial begin
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (pend_q.size() != 0 && pend_q[0].due <= cyc_n) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = pend_q[0].data;
        void'(pend_q.pop_front());
      end else begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = $urandom;
      end
    end
  end

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin : mon
    bit    up_acc, dn_acc, ack_v;
    wb_req_t r;
    rsp_t  e;
    up_acc = wbs_cyc_i && wbs_stb_i && !wbs_stall_o && !rst;
    dn_acc = wbm_stb_o && !wbm_stall_i && !rst;
    ack_v  = wbm_ack_i && (out_m != 0);
    if (model_on) begin
      check("stb_model", 32'(wbm_stb_o), 32'((occ != 0) && (out_m < MAXO)));
      check("stall_model", 32'(wbs_stall_o), 32'(occ == 2));
      if (wbs_stall_o) saw_stall = 1'b1;
      if (out_m == MAXO - 1 && dn_acc && ack_v) sim_hits++;
    end
    if (dn_acc) begin
      last_pop = cyc_n;
      check("dn_req_level", 32'(exp_req_q.size() != 0), 1);
      if (exp_req_q.size() != 0) begin
        r = exp_req_q.pop_front();
        check("dn_adr", 32'(wbm_adr_o), 32'(r.adr));
        check("dn_we", 32'(wbm_we_o), 32'(r.we));
        check("dn_sel", 32'(wbm_sel_o), 32'(r.sel));
        if (r.we) check("dn_dat", wbm_dat_o, r.dat);
      end
      if (slave_on) pend_q.push_back('{due: cyc_n + ack_delay, data: rd_model(wbm_adr_o)});
    end
    if (wbs_ack_o === 1'b1) begin
      ack_count++;
      check("rsp_q_level", 32'(rsp_q.size() != 0), 1);
      if (rsp_q.size() != 0) begin
        e = rsp_q.pop_front();
        if (e.is_read) check("rd_data", wbs_dat_o, e.data);
      end
    end
    if (wbs_err_o === 1'b1) err_count++;
    if (up_acc) begin
      exp_req_q.push_back('{adr: wbs_adr_i, dat: wbs_dat_i, we: wbs_we_i, sel: wbs_sel_i});
      rsp_q.push_back('{is_read: !wbs_we_i, data: rd_model(wbs_adr_i)});
    end
    occ   = occ + int'(up_acc) - int'(dn_acc);
    out_m = out_m + int'(dn_acc) - int'(ack_v);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Presents one request and returns one cycle after it was accepted.
  task automatic issue(input logic [31:2] adr, input logic [31:0] dat, input logic we);
    bit done = 1'b0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    wbs_adr_i = adr;  wbs_dat_i = dat; wbs_we_i = we;
    wbs_sel_i = dat[3:0] | 4'b0001;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = !wbs_stall_o;
      tick();
    end
    check("issue_accepted", 32'(done), 1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((rsp_q.size() != 0 || occ != 0 || out_m != 0) && n < budget) begin
      tick(); n++;
    end
    check(tag, rsp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ack"},   32'(wbs_ack_o), 0);
    check({pfx, "_err"},   32'(wbs_err_o), 0);
    check({pfx, "_stall"}, 32'(wbs_stall_o), 0);
    check({pfx, "_dat"},   wbs_dat_o, 0);
    check({pfx, "_stb"},   32'(wbm_stb_o), 0);
    check({pfx, "_cyc"},   32'(wbm_cyc_o), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, e0, ecyc, n;
    bit hit;
    rst = 1'b1; wbs_adr_i = '0; wbs_dat_i = '0; wbs_we_i = 1'b0; wbs_sel_i = '0;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbm_stall_i = 1'b0; wbm_err_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    tick();

    // Single read of 0x1000, slave acks two cycles after acceptance.
    model_on = 1'b1; slave_on = 1'b1; ack_delay = 2;
    issue(30'h400, 32'h0, 1'b0);
    wbs_stb_i = 1'b0;
    @(negedge clk);
    check("rd_stb_latency", 32'(wbm_stb_o), 1);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      tick(); @(negedge clk); hit = wbm_ack_i;
    end
    check("rd_wbm_ack_seen", 32'(hit), 1);
    check("rd_ack_not_early", 32'(wbs_ack_o), 0);
    tick(); @(negedge clk);
    check("rd_ack_latency", 32'(wbs_ack_o), 1);
    check("rd_dat_deadbeef", wbs_dat_o, 32'hDEAD_BEEF);
    tick();
    wbs_cyc_i = 1'b0; tick(); tick();

    // Four-word burst write with the downstream stalled for three cycles.
    a0 = ack_count; ack_delay = 1; wbm_stall_i = 1'b1; saw_stall = 1'b0;
    fork
      begin repeat (3) @(posedge clk); #1; wbm_stall_i = 1'b0; end
    join_none
    for (int i = 0; i < 4; i++) issue(30'h800 + 30'(i), 32'hC0DE_0010 + 32'(i * 3), 1'b1);
    wbs_stb_i = 1'b0;
    wait_drain("burst_drain", 40);
    check("burst_acks", ack_count - a0, 4);
    check("burst_saw_stall", 32'(saw_stall), 1);
    wbs_cyc_i = 1'b0; tick(); tick();

    // Eight reads against a slow slave: outstanding saturates, then pop+ack at MAX-1.
    a0 = ack_count; ack_delay = 5; sim_hits = 0;
    for (int i = 0; i < 8; i++) issue(30'h900 + 30'(i), 32'h0, 1'b0);
    wbs_stb_i = 1'b0;
    wait_drain("sat_drain", 60);
    check("sat_acks", ack_count - a0, 8);
    check("sat_pop_ack_hit", 32'(sim_hits != 0), 1);
    wbs_cyc_i = 1'b0; tick(); tick();

    // Upstream abort with two outstanding reads and late acks.
    a0 = ack_count; e0 = err_count; ack_delay = 8;
    issue(30'h980, 32'h0, 1'b0);
    issue(30'h981, 32'h0, 1'b0);
    wbs_stb_i = 1'b0;
    n = 0;
    while (out_m != 2 && n < 20) begin tick(); n++; end
    check("abort_two_outstanding", out_m, 2);
    model_on = 1'b0; wbs_cyc_i = 1'b0;
    rsp_q.delete(); exp_req_q.delete(); occ = 0; out_m = 0;
    @(negedge clk);
    check("abort_cyc_same_cycle", 32'(wbm_cyc_o), 1);
    tick(); @(negedge clk);
    check("abort_cyc_low", 32'(wbm_cyc_o), 0);
    check("abort_stall", 32'(wbs_stall_o), 1);
    check("abort_stb_low", 32'(wbm_stb_o), 0);
    tick(); @(negedge clk);
    check("abort_idle_stall", 32'(wbs_stall_o), 0);
    repeat (12) tick();
    check("abort_no_ack", ack_count - a0, 0);
    check("abort_no_err", err_count - e0, 0);

    // Timeout: the slave never acks.
    e0 = err_count; a0 = ack_count; slave_on = 1'b0; model_on = 1'b1;
    issue(30'hA00, 32'h0, 1'b0);
    wbs_stb_i = 1'b0; model_on = 1'b0;
    hit = 1'b0; ecyc = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (wbs_err_o === 1'b1) begin hit = 1'b1; ecyc = cyc_n; end
      else tick();
    end
    check("timeout_seen", 32'(hit), 1);
    check("timeout_latency", ecyc - last_pop, TO + 1);
    check("timeout_no_ack", 32'(wbs_ack_o), 0);
    check("timeout_cyc_low", 32'(wbm_cyc_o), 0);
    tick();
    wbs_cyc_i = 1'b0; rsp_q.delete(); exp_req_q.delete(); occ = 0; out_m = 0;
    @(negedge clk);
    check("timeout_single_pulse", 32'(wbs_err_o), 0);
    check("timeout_then_idle", 32'(wbs_stall_o), 0);
    check("timeout_cyc_still_low", 32'(wbm_cyc_o), 0);
    repeat (3) tick();
    check("timeout_err_count", err_count - e0, 1);
    check("timeout_ack_count", ack_count - a0, 0);

    // Reset with a full request buffer.
    a0 = ack_count; slave_on = 1'b1; ack_delay = 1; wbm_stall_i = 1'b1; model_on = 1'b1;
    issue(30'hB00, 32'h1111_2222, 1'b1);
    issue(30'hB01, 32'h3333_4444, 1'b1);
    model_on = 1'b0;
    @(negedge clk);
    check("full_stall", 32'(wbs_stall_o), 1);
    tick();
    rst = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    rsp_q.delete(); exp_req_q.delete(); occ = 0; out_m = 0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    tick();
    wbm_stall_i = 1'b0;
    repeat (6) tick();
    check("midrst_no_ack", ack_count - a0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
